// File: rtl/mop_seq_pkg.sv
// ============================================================================
// Module   : mop_seq_pkg
// Purpose  : Shared types and constants for the MOP load-sequence master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mop_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_TGT   = 3'd2,
    S_MODE  = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int unsigned WORDS_SHORT      = 4;
  localparam int unsigned WORDS_LONG       = 8;
  localparam int unsigned FIFO_DEPTH       = 8;
  localparam logic [31:0] SEQ_ADDR_DEFAULT = 32'h0000_000C;

  // Mode bit 1 alone selects the short load; bit 0 never affects the length.
  function automatic logic [3:0] words_for_mode(input logic [1:0] mode);
    return mode[1] ? 4'(WORDS_SHORT) : 4'(WORDS_LONG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mop_seq_fifo.sv
// ============================================================================
// Module   : mop_seq_fifo
// Purpose  : 8x32 synchronous instruction-word FIFO with push/pop/flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mop_seq_fifo
  import mop_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  input  logic        i_flush,
  output logic [31:0] o_head,
  output logic [3:0]  o_fill,
  output logic        o_full,
  output logic        o_empty
);

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_fill;
  logic        w_push;
  logic        w_pop;

  assign o_full  = (r_fill == 4'(FIFO_DEPTH));
  assign o_empty = (r_fill == 4'd0);
  assign o_fill  = r_fill;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_fill   <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 4'd1;
        2'b01:   r_fill <= r_fill - 4'd1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/mop_seq_master.sv
// ============================================================================
// Module   : mop_seq_master
// Purpose  : Serialises START/target/mode/instruction writes to the MOP slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mop_seq_master
  import mop_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TGT_WIDTH  = 5,
  parameter logic [ADDR_WIDTH-1:0] SEQ_ADDR   = ADDR_WIDTH'(SEQ_ADDR_DEFAULT),
  parameter int                    GAP_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  word_valid_i,
  input  logic [DATA_WIDTH-1:0] word_data_i,
  output logic                  word_ready_o,
  input  logic                  cmd_valid_i,
  input  logic [TGT_WIDTH-1:0]  cmd_target_i,
  input  logic [1:0]            cmd_mode_i,
  output logic                  cmd_ready_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_write_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  input  logic                  bus_error_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t                 r_state, w_state_nxt;
  state_t                 r_after, w_after_nxt;
  logic [TGT_WIDTH-1:0]   r_tgt;
  logic [1:0]             r_mode;
  logic [3:0]             r_wcnt;
  logic [GW-1:0]          r_gap;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  w_head;
  logic [3:0]             w_fill;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_cmd_acc;
  logic                   w_xfer;
  logic                   w_pop;
  logic                   w_flush;

  assign cmd_ready_o  = (r_state == S_IDLE) && (w_fill >= words_for_mode(cmd_mode_i));
  assign w_cmd_acc    = cmd_valid_i && cmd_ready_o;
  assign w_xfer       = bus_valid_o && bus_ready_i;
  assign w_pop        = w_xfer && (r_state == S_DATA) && !w_empty;
  assign w_flush      = w_xfer && bus_error_i;
  assign word_ready_o = !w_full;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;

  mop_seq_fifo u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (word_valid_i),
    .i_data  (word_data_i),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_fill  (w_fill),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_after <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_after <= w_after_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_after_nxt = r_after;
    bus_valid_o = 1'b0;
    bus_write_o = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_wstrb_o = 4'h0;
    case (r_state)
      S_IDLE:  if (w_cmd_acc) w_state_nxt = S_START;
      S_START, S_TGT, S_MODE, S_DATA: begin
        bus_valid_o = 1'b1;
        bus_write_o = 1'b1;
        bus_addr_o  = SEQ_ADDR;
        bus_wstrb_o = 4'hF;
        case (r_state)
          S_TGT:   bus_wdata_o = DATA_WIDTH'(r_tgt);
          S_MODE:  bus_wdata_o = DATA_WIDTH'(r_mode);
          S_DATA:  bus_wdata_o = w_head;
          default: bus_wdata_o = '0;
        endcase
        if (w_xfer) begin
          // An errored write still counts as complete; the sequence aborts.
          if (bus_error_i) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            case (r_state)
              S_START: w_after_nxt = S_TGT;
              S_TGT:   w_after_nxt = S_MODE;
              S_MODE:  w_after_nxt = S_DATA;
              default: w_after_nxt = (r_wcnt + 4'd1 == words_for_mode(r_mode)) ? S_DONE : S_DATA;
            endcase
          end
        end
      end
      S_GAP:   if (r_gap == GW'(GAP_CYCLES - 1)) w_state_nxt = r_after;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tgt  <= '0;
      r_mode <= 2'b00;
      r_wcnt <= 4'd0;
      r_gap  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_flush;
      r_gap <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
      if (w_cmd_acc) begin
        r_tgt  <= cmd_target_i;
        r_mode <= cmd_mode_i;
        r_wcnt <= 4'd0;
      end else if (w_pop) begin
        r_wcnt <= r_wcnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mop_seq_master.sv
// ============================================================================
// Module   : tb_mop_seq_master
// Purpose  : Scoreboard bench for the MOP load-sequence master.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mop_seq_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_data_i = '0;
  logic        word_ready_o;
  logic        cmd_valid_i = 1'b0;
  logic [4:0]  cmd_target_i = '0;
  logic [1:0]  cmd_mode_i = '0;
  logic        cmd_ready_o;
  logic [31:0] bus_addr_o;
  logic        bus_write_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_valid_o;
  logic        bus_ready_i = 1'b1;
  logic        bus_error_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  mop_seq_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_ready_o(word_ready_o),
    .cmd_valid_i(cmd_valid_i), .cmd_target_i(cmd_target_i), .cmd_mode_i(cmd_mode_i),
    .cmd_ready_o(cmd_ready_o),
    .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_error_i(bus_error_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0, err_cnt = 0;
  int          last_done = -1, last_err = -1;
  logic        prev_acc = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus monitor: scoreboard on accepted writes, idle gap and hold-while-stalled.
  always @(negedge clk_i) begin
    exp_t e;
    if (done_o) begin done_cnt++; last_done = cyc; end
    if (err_o)  begin err_cnt++;  last_err  = cyc; end
    if (!rst_i && bus_valid_o && bus_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d data=%h expected none", cyc, bus_wdata_o);
      end else begin
        e = sb.pop_front();
        if (bus_wdata_o !== e.data || bus_addr_o !== 32'hC || bus_wstrb_o !== 4'hF ||
            bus_write_o !== 1'b1 || cyc != e.cyc) begin
          errors++;
          $display("FAIL write got data=%h addr=%h strb=%h wr=%b cyc=%0d expected data=%h addr=0000000c strb=f wr=1 cyc=%0d",
                   bus_wdata_o, bus_addr_o, bus_wstrb_o, bus_write_o, cyc, e.data, e.cyc);
        end
      end
    end
    if (!rst_i && prev_acc) begin
      checks++;
      if (bus_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL gap cyc=%0d valid=%b expected 0", cyc, bus_valid_o);
      end
    end
    if (!rst_i && prev_stall) begin
      checks++;
      if (bus_valid_o !== 1'b1 || bus_addr_o !== prev_addr || bus_wdata_o !== prev_data) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%b addr=%h data=%h expected 1 %h %h",
                 cyc, bus_valid_o, bus_addr_o, bus_wdata_o, prev_addr, prev_data);
      end
    end
    prev_acc   = !rst_i && bus_valid_o && bus_ready_i;
    prev_stall = !rst_i && bus_valid_o && !bus_ready_i;
    prev_addr  = bus_addr_o;
    prev_data  = bus_wdata_o;
  end

  task automatic push_word(input logic [31:0] d);
    word_valid_i = 1'b1;
    word_data_i  = d;
    if (model.size() < 8) model.push_back(d);
    @(posedge clk_i); #1;
    word_valid_i = 1'b0;
  endtask

  task automatic accept_cmd(input logic [4:0] tgt, input logic [1:0] mode,
                            output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    cmd_valid_i  = 1'b1;
    cmd_target_i = tgt;
    cmd_mode_i   = mode;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin ok = 1'b1; t = cyc; end
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  // Queues the writes this command should produce; nwr limits it for aborted runs.
  task automatic load_expected(input int t, input logic [4:0] tgt, input logic [1:0] mode,
                               input int stall, input int nwr);
    int   need;
    exp_t e;
    need = mode[1] ? 4 : 8;
    for (int w = 0; w < 3 + need; w++) begin
      if (w == 0)      e.data = 32'h0;
      else if (w == 1) e.data = {27'h0, tgt};
      else if (w == 2) e.data = {30'h0, mode};
      else             e.data = (model.size() > 0) ? model.pop_front() : 32'hDEAD_BEEF;
      e.cyc = t + 1 + 2 * w + ((w >= 1) ? stall : 0);
      if (w < nwr) sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    cmd_mode_i = 2'b10;
    @(negedge clk_i);
    checks++;
    if ({bus_valid_o, bus_write_o, busy_o, done_o, err_o, cmd_ready_o} !== 6'b0 ||
        bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_wstrb_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs v=%b w=%b busy=%b done=%b err=%b crdy=%b addr=%h data=%h strb=%h expected all 0",
               bus_valid_o, bus_write_o, busy_o, done_o, err_o, cmd_ready_o,
               bus_addr_o, bus_wdata_o, bus_wstrb_o);
    end
    checks++;
    if (word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_word_ready got %b expected 1", word_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_four_words();
    int t; bit ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + i);
    accept_cmd(5'd5, 2'b10, t, ok);
    load_expected(t, 5'd5, 2'b10, 0, 7);
    checks++;
    if (!ok) begin errors++; $display("FAIL four_accept got none expected accept"); end
    repeat (17) @(negedge clk_i);
    checks++;
    if (done_cnt != d0 + 1 || last_done != t + 15) begin
      errors++;
      $display("FAIL four_done got count=%0d cyc=%0d expected count=1 cyc=%0d", done_cnt - d0, last_done, t + 15);
    end
    checks++;
    if (sb.size() != 0 || err_cnt != e0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b0 || word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL four_end got left=%0d errs=%0d busy=%b crdy=%b wrdy=%b expected 0 0 0 0 1",
               sb.size(), err_cnt - e0, busy_o, cmd_ready_o, word_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_eight_words();
    int t; bit ok; int d0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) push_word($urandom);
    @(negedge clk_i);
    checks++;
    if (word_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_word_ready got %b expected 0", word_ready_o);
    end
    @(posedge clk_i); #1;
    push_word(32'hBAD0_0009);
    accept_cmd(5'd14, 2'b00, t, ok);
    load_expected(t, 5'd14, 2'b00, 0, 11);
    checks++;
    if (!ok) begin errors++; $display("FAIL eight_accept got none expected accept"); end
    repeat (25) @(negedge clk_i);
    checks++;
    if (done_cnt != d0 + 1 || last_done != t + 23 || sb.size() != 0) begin
      errors++;
      $display("FAIL eight_done got count=%0d cyc=%0d left=%0d expected 1 %0d 0",
               done_cnt - d0, last_done, sb.size(), t + 23);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_cmd_wait();
    int t, p; int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_word(32'hC000_0000 + i);
    cmd_valid_i = 1'b1; cmd_target_i = 5'd9; cmd_mode_i = 2'b10;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (cmd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_not_ready got %b expected 0", cmd_ready_o);
      end
    end
    @(posedge clk_i); #1;
    word_valid_i = 1'b1; word_data_i = 32'hC000_0003; model.push_back(32'hC000_0003);
    @(negedge clk_i);
    p = cyc;
    @(posedge clk_i); #1;
    word_valid_i = 1'b0;
    @(negedge clk_i);
    t = cyc;
    checks++;
    if (cmd_ready_o !== 1'b1 || t != p + 1) begin
      errors++;
      $display("FAIL wait_ready got %b at %0d expected 1 at %0d", cmd_ready_o, t, p + 1);
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    load_expected(t, 5'd9, 2'b10, 0, 7);
    repeat (17) @(negedge clk_i);
    checks++;
    if (done_cnt != d0 + 1 || last_done != t + 15 || sb.size() != 0) begin
      errors++;
      $display("FAIL wait_done got count=%0d cyc=%0d left=%0d expected 1 %0d 0",
               done_cnt - d0, last_done, sb.size(), t + 15);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_stall();
    int t; bit ok; int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hD000_0000 + i);
    accept_cmd(5'd7, 2'b10, t, ok);
    load_expected(t, 5'd7, 2'b10, 3, 7);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    bus_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 bus_ready_i = 1'b1;
    repeat (15) @(negedge clk_i);
    checks++;
    if (!ok || done_cnt != d0 + 1 || last_done != t + 18 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_done got ok=%0d count=%0d cyc=%0d left=%0d expected 1 1 %0d 0",
               ok, done_cnt - d0, last_done, sb.size(), t + 18);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_bus_error();
    int t; bit ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hE000_0000 + i);
    accept_cmd(5'd3, 2'b11, t, ok);
    load_expected(t, 5'd3, 2'b11, 0, 5);
    repeat (8) @(posedge clk_i);
    #1 bus_error_i = 1'b1;
    @(posedge clk_i); #1;
    bus_error_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || bus_valid_o !== 1'b0 || cyc != t + 10) begin
      errors++;
      $display("FAIL err_pulse got err=%b busy=%b valid=%b cyc=%0d expected 1 0 0 %0d",
               err_o, busy_o, bus_valid_o, cyc, t + 10);
    end
    repeat (6) @(negedge clk_i);
    checks++;
    if (err_cnt != e0 + 1 || done_cnt != d0 || sb.size() != 0 ||
        cmd_ready_o !== 1'b0 || word_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL err_after got errs=%0d dones=%0d left=%0d crdy=%b wrdy=%b expected 1 0 0 0 1",
               err_cnt - e0, done_cnt - d0, sb.size(), cmd_ready_o, word_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int t; bit ok;
    for (int i = 0; i < 8; i++) push_word(32'hF000_0000 + i);
    accept_cmd(5'd1, 2'b00, t, ok);
    load_expected(t, 5'd1, 2'b00, 0, 3);
    repeat (6) @(posedge clk_i);
    #1 bus_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (bus_valid_o !== 1'b0 || busy_o !== 1'b0 || word_ready_o !== 1'b1 ||
        cmd_ready_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b busy=%b wrdy=%b crdy=%b left=%0d expected 0 0 1 0 0",
               bus_valid_o, busy_o, word_ready_o, cmd_ready_o, sb.size());
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_four_words();
    test_eight_words();
    test_cmd_wait();
    test_stall();
    test_bus_error();
    test_reset_mid();
    test_four_words();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mop_seq_master.md
Name: mop_seq_master

Overview:
- Register-bus initiator that drives the MOP load protocol into the MOP wrapper's slave port.
- Write sequence: start word (0), target index, mode, then 4 or 8 instruction words.
- Firmware or a local controller pushes instruction words into an internal 8-entry buffer, then issues a command. The block serialises the writes with a mandatory idle gap after each, so the wrapper's per-word load pulse and end-of-sequence detection see non-write cycles.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width (fixed 32; other values unsupported).
- TGT_WIDTH, 5, width of peripheral target index.
- SEQ_ADDR, 32'h0000_000C, address of every sequence write. Word offset 3 keeps clear of the wrapper's override/source/target registers at offsets 0–2.
- GAP_CYCLES, 1, idle cycles (bus_valid_o low) after each accepted write; minimum 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- word_valid_i  in  1  instruction word push request
- word_data_i  in  32  instruction word
- word_ready_o  out  1  buffer can accept a word (fill < 8)
- cmd_valid_i  in  1  start sequence request
- cmd_target_i  in  TGT_WIDTH  peripheral index to load
- cmd_mode_i  in  2  change/mode field; bit1=1 selects 4 words, else 8
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- bus_addr_o  out  ADDR_WIDTH  write address
- bus_write_o  out  1  high whenever bus_valid_o high
- bus_wdata_o  out  32  write data
- bus_wstrb_o  out  4  constant 4'hF while valid, else 0
- bus_valid_o  out  1  transfer request
- bus_ready_i  in  1  slave accepts transfer
- bus_error_i  in  1  slave error, sampled with ready
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse, sequence complete
- err_o  out  1  one-cycle pulse, sequence aborted on bus error

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0, except word_ready_o=1. cmd_ready_o=0 because fill=0.
- need = cmd_mode_i[1] ? 4 : 8.
- cmd_ready_o = (state==IDLE) && (fill >= need). It is combinational on cmd_mode_i.
- On command accept, target and mode are latched and the word counter is cleared.
- FIFO: push when word_valid_i && word_ready_o. Pop on each accepted DATA write. Simultaneous push and pop leaves fill unchanged. Push while full is ignored. Pushes are allowed in any state.
- States: IDLE → START → GAP → TGT → GAP → MODE → GAP → DATA → GAP → (DATA | DONE) → IDLE.
- Write contents by state:
  - START: wdata = 0.
  - TGT: wdata = zero-extended target.
  - MODE: wdata = {30'b0, mode}.
  - DATA: wdata = FIFO head.
- In START/TGT/MODE/DATA, bus_valid_o=1 with addr=SEQ_ADDR. addr/wdata/valid are held stable until bus_ready_i. The transfer completes on the cycle valid && ready.
- GAP: valid=0 for GAP_CYCLES. It then goes to the next write state, or to DONE after word count reaches need.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing with bus_ready_i tied 1 and GAP_CYCLES=1, command accepted at cycle T:
  - writes at T+1, T+3, T+5, then words from T+7 every 2 cycles;
  - 4-word mode: last word T+13, done_o T+15;
  - 8-word mode: last word T+21, done_o T+23.
- Bus error (ready && error) in any write state: that write counts as complete. err_o pulses next cycle, FIFO is flushed, state goes to IDLE, done_o is not asserted.
- mode 2'b11 behaves as 4-word (bit1 decides); mode is sent unmodified.
- Reset mid-sequence: bus_valid_o=0 and FIFO empty from the next edge. The slave may be left mid-sequence; software recovers by issuing a full sequence.

Decomposition:
- Package mop_seq_pkg: state enum (IDLE, START, TGT, MODE, DATA, GAP, DONE), words-per-mode constants (4, 8), default SEQ_ADDR, FIFO depth 8.
- Sub-module mop_seq_fifo: 8x32 synchronous FIFO with push/pop/flush, 4-bit fill count, full/empty flags.

Test Plan:
- Push 4 words (A0..A3), command target=5, mode=2 at T → writes {0,5,2,A0..A3} to 0x0C at T+1,+3,...,+13; valid low between writes; done_o at T+15; fill=0.
- Push 8 words, command target=14, mode=0 → 11 writes, last word at T+21, done_o at T+23, wstrb=F on every write.
- Push 3 words, hold cmd_valid_i with mode=2 → cmd_ready_o=0 until the 4th push, then the command is accepted the next cycle.
- bus_ready_i low for 3 cycles during the TGT write → addr/wdata/valid stable for 4 cycles; the rest of the schedule shifts by 3.
- bus_error_i with ready on the 2nd data word → err_o pulse, no done_o, fill=0, busy_o=0 after one cycle.
- rst_i asserted during DATA → next cycle: bus_valid_o=0, busy_o=0, word_ready_o=1, cmd_ready_o=0.
